// File: rtl/control_unit_stack.sv
// Multicycle control unit for the accumulator CPU.
// Adds a return-address stack for CALL/RET, inverted jumps and HLT with resume.
module control_unit_stack #(
    parameter int WORD_W      = 8,
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4,
    parameter int SP_W        = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic [WORD_W-1:0] mem_rdata_i,
    output logic [WORD_W-1:0] reg_wdata_o,
    output logic              ir_we_o,
    output logic              a_we_o,
    output logic              mdr_we_o,
    output logic              opnd_we_o,
    output logic              out_we_o,
    input  logic [WORD_W-1:0] ir_i,
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] mdr_i,
    input  logic [WORD_W-1:0] opnd_i,
    input  logic [WORD_W-1:0] in_i,
    output logic [2:0]        alu_oc_o,
    output logic [WORD_W-1:0] alu_a_o,
    output logic [WORD_W-1:0] alu_b_o,
    input  logic [WORD_W-1:0] alu_res_i,
    input  logic              alu_carry_i,
    input  logic              bl_prog_i,
    input  logic              bl_we_i,
    input  logic [ADDR_W-1:0] bl_addr_i,
    input  logic [WORD_W-1:0] bl_data_i,
    input  logic              resume_i,
    output logic              halted_o,
    output logic [1:0]        err_code_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [SP_W-1:0]   sp_o
);

    localparam logic [3:0] S_RESET     = 4'd0;
    localparam logic [3:0] S_PROG      = 4'd1;
    localparam logic [3:0] S_FETCH_I   = 4'd2;
    localparam logic [3:0] S_DECODE    = 4'd3;
    localparam logic [3:0] S_FETCH_O   = 4'd4;
    localparam logic [3:0] S_FETCH_MDR = 4'd5;
    localparam logic [3:0] S_EXEC_ALU  = 4'd6;
    localparam logic [3:0] S_EXEC      = 4'd7;
    localparam logic [3:0] S_HALT      = 4'd8;
    localparam logic [3:0] S_TRAP      = 4'd9;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_INC  = 5'h05;
    localparam logic [4:0] OP_DEC  = 5'h06;
    localparam logic [4:0] OP_JMP  = 5'h08;
    localparam logic [4:0] OP_JZ   = 5'h09;
    localparam logic [4:0] OP_JC   = 5'h0A;
    localparam logic [4:0] OP_LD   = 5'h0B;
    localparam logic [4:0] OP_ST   = 5'h0C;
    localparam logic [4:0] OP_IN   = 5'h0D;
    localparam logic [4:0] OP_OUT  = 5'h0E;
    localparam logic [4:0] OP_LDI  = 5'h0F;
    localparam logic [4:0] OP_CALL = 5'h10;
    localparam logic [4:0] OP_RET  = 5'h11;
    localparam logic [4:0] OP_HLT  = 5'h12;
    localparam logic [4:0] OP_JNZ  = 5'h13;
    localparam logic [4:0] OP_JNC  = 5'h14;

    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              z_q, z_d, c_q, c_d;
    logic [1:0]        err_q, err_d;
    logic              push;
    logic [ADDR_W-1:0] stack_q [2**SP_W];

    logic [4:0]        op;
    logic [ADDR_W-1:0] opnd_addr, pc_inc;
    logic [SP_W-1:0]   sp_dec;
    logic              is_alu, is_incdec, has_opnd, illegal, need_mdr;
    logic              unused_ok;

    assign op        = ir_i[4:0];
    assign opnd_addr = opnd_i[ADDR_W-1:0];
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign sp_dec    = sp_q - SP_W'(1);
    assign unused_ok = ^{ir_i, opnd_i};

    assign is_alu    = (op != OP_NOP) && (op <= 5'h07);
    assign is_incdec = (op == OP_INC) || (op == OP_DEC);
    assign illegal   = (op > OP_JNC);
    assign need_mdr  = is_alu || (op == OP_LD);
    assign has_opnd  = (is_alu && !is_incdec)
                     || ((op >= OP_JMP) && (op <= OP_ST))
                     || (op == OP_LDI) || (op == OP_CALL)
                     || (op == OP_JNZ) || (op == OP_JNC);

    assign halted_o   = (state_q == S_HALT) || (state_q == S_TRAP);
    assign err_code_o = err_q;
    assign pc_o       = pc_q;
    assign sp_o       = sp_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sp_d        = sp_q;
        z_d         = z_q;
        c_d         = c_q;
        err_d       = err_q;
        push        = 1'b0;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        reg_wdata_o = '0;
        ir_we_o     = 1'b0;
        a_we_o      = 1'b0;
        mdr_we_o    = 1'b0;
        opnd_we_o   = 1'b0;
        out_we_o    = 1'b0;
        alu_oc_o    = '0;
        alu_a_o     = '0;
        alu_b_o     = '0;
        case (state_q)
            S_RESET: state_d = bl_prog_i ? S_PROG : S_FETCH_I;
            S_PROG: begin
                mem_we_o    = bl_we_i;
                mem_addr_o  = bl_addr_i;
                mem_wdata_o = bl_data_i;
                pc_d        = '0;
                sp_d        = '0;
                z_d         = 1'b0;
                c_d         = 1'b0;
                err_d       = 2'b00;
                state_d     = bl_prog_i ? S_PROG : S_FETCH_I;
            end
            S_FETCH_I: begin
                mem_re_o    = 1'b1;
                mem_addr_o  = pc_q;
                reg_wdata_o = mem_rdata_i;
                ir_we_o     = 1'b1;
                pc_d        = pc_inc;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_NOP) begin
                    state_d = S_FETCH_I;
                end else if (illegal) begin
                    err_d   = 2'b11;
                    state_d = S_TRAP;
                end else if (has_opnd) begin
                    state_d = S_FETCH_O;
                end else if (need_mdr) begin
                    state_d = S_FETCH_MDR;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_FETCH_O: begin
                mem_re_o    = 1'b1;
                mem_addr_o  = pc_q;
                reg_wdata_o = mem_rdata_i;
                opnd_we_o   = 1'b1;
                pc_d        = pc_inc;
                state_d     = need_mdr ? S_FETCH_MDR : S_EXEC;
            end
            S_FETCH_MDR: begin
                mdr_we_o = 1'b1;
                if (is_incdec) begin
                    reg_wdata_o = WORD_W'(1);
                end else begin
                    mem_re_o    = 1'b1;
                    mem_addr_o  = opnd_addr;
                    reg_wdata_o = mem_rdata_i;
                end
                state_d = is_alu ? S_EXEC_ALU : S_EXEC;
            end
            S_EXEC_ALU: begin
                alu_oc_o    = ir_i[2:0];
                alu_a_o     = a_i;
                alu_b_o     = mdr_i;
                reg_wdata_o = alu_res_i;
                a_we_o      = 1'b1;
                c_d         = alu_carry_i;
                z_d         = (alu_res_i == '0);
                state_d     = bl_prog_i ? S_PROG : S_FETCH_I;
            end
            S_EXEC: begin
                state_d = bl_prog_i ? S_PROG : S_FETCH_I;
                unique case (op)
                    OP_JMP: pc_d = opnd_addr;
                    OP_JZ:  if (z_q)  pc_d = opnd_addr;
                    OP_JNZ: if (!z_q) pc_d = opnd_addr;
                    OP_JC:  if (c_q)  pc_d = opnd_addr;
                    OP_JNC: if (!c_q) pc_d = opnd_addr;
                    OP_LD: begin
                        a_we_o      = 1'b1;
                        reg_wdata_o = mdr_i;
                    end
                    OP_ST: begin
                        mem_we_o    = 1'b1;
                        mem_addr_o  = opnd_addr;
                        mem_wdata_o = a_i;
                    end
                    OP_IN: begin
                        a_we_o      = 1'b1;
                        reg_wdata_o = in_i;
                    end
                    OP_OUT: begin
                        out_we_o    = 1'b1;
                        reg_wdata_o = a_i;
                    end
                    OP_LDI: begin
                        a_we_o      = 1'b1;
                        reg_wdata_o = opnd_i;
                    end
                    OP_CALL: begin
                        if (sp_q == SP_FULL) begin
                            err_d   = 2'b01;
                            state_d = S_TRAP;
                        end else begin
                            push = 1'b1;
                            sp_d = sp_q + SP_W'(1);
                            pc_d = opnd_addr;
                        end
                    end
                    OP_RET: begin
                        if (sp_q == '0) begin
                            err_d   = 2'b10;
                            state_d = S_TRAP;
                        end else begin
                            sp_d = sp_dec;
                            pc_d = stack_q[sp_dec];
                        end
                    end
                    OP_HLT:  state_d = S_HALT;
                    default: ;
                endcase
            end
            S_HALT: begin
                if (bl_prog_i)     state_d = S_PROG;
                else if (resume_i) state_d = S_FETCH_I;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_RESET;
            pc_q    <= '0;
            sp_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            z_q     <= z_d;
            c_q     <= c_d;
            err_q   <= err_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk_i) begin
        if (push) stack_q[sp_q] <= pc_q;
    end

endmodule
